// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM: sequences ALU, register file and the shared memory port
// one instruction at a time, with a bounded memory wait and sticky fault flags.
module mc_controller #(
    parameter int WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_op,
    output logic [1:0] ext_op,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic [2:0] state,
    output logic       instr_done,
    output logic       illegal,
    output logic       mem_err
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_BRANCH = 3'd5
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_OR  = 4'd2;
    localparam logic [3:0] ALU_LUI = 4'd3;
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t     r_state;
    logic [7:0] r_wait_cnt;
    logic       r_illegal;
    logic       r_mem_err;

    state_t     w_state_next;
    logic [7:0] w_wait_next;
    logic       w_set_illegal;
    logic       w_mem_phase;
    logic       w_timeout;

    logic w_rtype, w_addu, w_subu, w_jr, w_ori, w_lui, w_lw, w_sw, w_beq, w_j, w_jal;
    logic w_exec_op;

    assign w_rtype   = (op == 6'h00);
    assign w_addu    = w_rtype && (funct == 6'h21);
    assign w_subu    = w_rtype && (funct == 6'h23);
    assign w_jr      = w_rtype && (funct == 6'h08);
    assign w_ori     = (op == 6'h0d);
    assign w_lui     = (op == 6'h0f);
    assign w_lw      = (op == 6'h23);
    assign w_sw      = (op == 6'h2b);
    assign w_beq     = (op == 6'h04);
    assign w_j       = (op == 6'h02);
    assign w_jal     = (op == 6'h03);
    assign w_exec_op = w_addu || w_subu || w_ori || w_lui || w_lw || w_sw;

    // The abort fires on the cycle whose stall would make the count reach WAIT_MAX.
    assign w_mem_phase = (r_state == S_FETCH) || (r_state == S_MEM);
    assign w_timeout   = w_mem_phase && !mem_ready && (r_wait_cnt == WAIT_LAST);
    assign w_wait_next = (w_mem_phase && !mem_ready && !w_timeout) ? r_wait_cnt + 8'd1 : 8'd0;

    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 2'd0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        alu_op        = ALU_ADD;
        ext_op        = 2'd0;
        reg_write     = 1'b0;
        reg_dst       = 2'd0;
        mem_to_reg    = 2'd0;
        instr_done    = 1'b0;
        w_set_illegal = 1'b0;
        w_state_next  = r_state;
        case (r_state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'd1;
                if (w_timeout) begin
                    instr_done = 1'b1;
                end else if (mem_ready) begin
                    ir_write     = 1'b1;
                    pc_write     = 1'b1;
                    w_state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b    = 2'd3;
                ext_op       = 2'd1;
                w_state_next = S_FETCH;
                if (w_j || w_jal) begin
                    pc_write   = 1'b1;
                    pc_src     = 2'd3;
                    instr_done = 1'b1;
                    if (w_jal) begin
                        reg_write  = 1'b1;
                        reg_dst    = 2'd2;
                        mem_to_reg = 2'd2;
                    end
                end else if (w_jr) begin
                    pc_write   = 1'b1;
                    pc_src     = 2'd2;
                    instr_done = 1'b1;
                end else if (w_beq) begin
                    w_state_next = S_BRANCH;
                end else if (w_exec_op) begin
                    w_state_next = S_EXEC;
                end else begin
                    w_set_illegal = 1'b1;
                    instr_done    = 1'b1;
                end
            end
            S_EXEC: begin
                if (w_addu || w_subu) begin
                    alu_src_a = 1'b1;
                    alu_op    = w_subu ? ALU_SUB : ALU_ADD;
                end else if (w_ori) begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd2;
                    alu_op    = ALU_OR;
                end else if (w_lui) begin
                    alu_src_b = 2'd2;
                    alu_op    = ALU_LUI;
                end else if (w_lw || w_sw) begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd2;
                    ext_op    = 2'd1;
                end
                w_state_next = (w_lw || w_sw) ? S_MEM : S_WB;
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = w_sw;
                if (w_timeout) begin
                    instr_done   = 1'b1;
                    w_state_next = S_FETCH;
                end else if (mem_ready) begin
                    instr_done   = w_sw;
                    w_state_next = w_sw ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                reg_write    = 1'b1;
                reg_dst      = w_rtype ? 2'd1 : 2'd0;
                mem_to_reg   = w_lw ? 2'd1 : 2'd0;
                instr_done   = 1'b1;
                w_state_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a    = 1'b1;
                alu_op       = ALU_SUB;
                instr_done   = 1'b1;
                w_state_next = S_FETCH;
                if (zero) begin
                    pc_write = 1'b1;
                    pc_src   = 2'd1;
                end
            end
            default: w_state_next = S_FETCH;
        endcase
        // Nothing may strobe while reset is held; the abandoned instruction leaves no trace.
        if (reset) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_src     = 2'd0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'd0;
            alu_op     = ALU_ADD;
            ext_op     = 2'd0;
            reg_write  = 1'b0;
            reg_dst    = 2'd0;
            mem_to_reg = 2'd0;
            instr_done = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= 8'd0;
            r_illegal  <= 1'b0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_next;
            if (w_set_illegal) r_illegal <= 1'b1;
            if (w_timeout)     r_mem_err <= 1'b1;
        end
    end

    assign state   = r_state;
    assign illegal = r_illegal;
    assign mem_err = r_mem_err;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks each instruction class cycle by cycle and
// checks state, strobes and selects against hand-computed values.
module tb_mc_controller;
    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero, mem_ready;
    logic       mem_req, mem_we, ir_write, pc_write, reg_write, instr_done;
    logic [1:0] pc_src, alu_src_b, ext_op, reg_dst, mem_to_reg;
    logic       alu_src_a, illegal, mem_err;
    logic [3:0] alu_op;
    logic [2:0] state;
    logic [5:0] stb;

    int n_tests = 0;
    int n_fail  = 0;

    mc_controller #(.WAIT_MAX(15)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .ext_op(ext_op), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .state(state), .instr_done(instr_done),
        .illegal(illegal), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    // {mem_req, mem_we, ir_write, pc_write, reg_write, instr_done}
    assign stb = {mem_req, mem_we, ir_write, pc_write, reg_write, instr_done};

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic at(input string tag, input logic [2:0] st, input logic [5:0] s);
        @(negedge clk);
        chk({tag, ".state"}, 8'(state), 8'(st));
        chk({tag, ".strobes"}, 8'(stb), 8'(s));
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; op = 6'h00; funct = 6'h21; zero = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            at("rst", 3'd0, 6'b000000);
            chk("rst.illegal", 8'(illegal), 8'd0);
            chk("rst.mem_err", 8'(mem_err), 8'd0);
            nxt();
        end
        reset = 1'b0;
        $display("[TB] reset held 3 cycles, released");

        at("addu.F", 3'd0, 6'b101100); chk("addu.F.src_b", 8'(alu_src_b), 8'd1); nxt();
        at("addu.D", 3'd1, 6'b000000); chk("addu.D.src_b", 8'(alu_src_b), 8'd3); nxt();
        at("addu.E", 3'd2, 6'b000000);
        chk("addu.E.src_a", 8'(alu_src_a), 8'd1); chk("addu.E.alu_op", 8'(alu_op), 8'd0); nxt();
        at("addu.W", 3'd4, 6'b000011);
        chk("addu.W.reg_dst", 8'(reg_dst), 8'd1); chk("addu.W.m2r", 8'(mem_to_reg), 8'd0); nxt();
        $display("[TB] addu: 4 cycles");

        funct = 6'h23;
        at("subu.F", 3'd0, 6'b101100); nxt();
        at("subu.D", 3'd1, 6'b000000); nxt();
        at("subu.E", 3'd2, 6'b000000); chk("subu.E.alu_op", 8'(alu_op), 8'd1); nxt();
        at("subu.W", 3'd4, 6'b000011); nxt();
        $display("[TB] subu: 4 cycles");

        op = 6'h23;
        at("lw.F", 3'd0, 6'b101100); nxt();
        at("lw.D", 3'd1, 6'b000000); nxt();
        at("lw.E", 3'd2, 6'b000000);
        chk("lw.E.src_a", 8'(alu_src_a), 8'd1); chk("lw.E.src_b", 8'(alu_src_b), 8'd2);
        chk("lw.E.ext", 8'(ext_op), 8'd1); nxt();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            at("lw.Mwait", 3'd3, 6'b100000); nxt();
        end
        mem_ready = 1'b1;
        at("lw.M", 3'd3, 6'b100000); nxt();
        at("lw.W", 3'd4, 6'b000011);
        chk("lw.W.m2r", 8'(mem_to_reg), 8'd1); chk("lw.W.reg_dst", 8'(reg_dst), 8'd0); nxt();
        $display("[TB] lw: MEM held 4 cycles");

        op = 6'h2b;
        at("sw.F", 3'd0, 6'b101100); nxt();
        at("sw.D", 3'd1, 6'b000000); nxt();
        at("sw.E", 3'd2, 6'b000000); nxt();
        at("sw.M", 3'd3, 6'b110001); nxt();
        $display("[TB] sw: 4 cycles");

        op = 6'h04; zero = 1'b1;
        at("beqT.F", 3'd0, 6'b101100); nxt();
        at("beqT.D", 3'd1, 6'b000000); nxt();
        at("beqT.B", 3'd5, 6'b000101);
        chk("beqT.pc_src", 8'(pc_src), 8'd1); chk("beqT.alu_op", 8'(alu_op), 8'd1); nxt();
        $display("[TB] beq taken: 3 cycles");
        zero = 1'b0;
        at("beqN.F", 3'd0, 6'b101100); nxt();
        at("beqN.D", 3'd1, 6'b000000); nxt();
        at("beqN.B", 3'd5, 6'b000001); nxt();
        $display("[TB] beq not taken: 3 cycles");

        op = 6'h02;
        at("j.F", 3'd0, 6'b101100); nxt();
        at("j.D", 3'd1, 6'b000101); chk("j.pc_src", 8'(pc_src), 8'd3); nxt();
        $display("[TB] j: 2 cycles");

        op = 6'h03;
        at("jal.F", 3'd0, 6'b101100); nxt();
        at("jal.D", 3'd1, 6'b000111);
        chk("jal.pc_src", 8'(pc_src), 8'd3); chk("jal.reg_dst", 8'(reg_dst), 8'd2);
        chk("jal.m2r", 8'(mem_to_reg), 8'd2); nxt();
        $display("[TB] jal: 2 cycles");

        op = 6'h00; funct = 6'h08;
        at("jr.F", 3'd0, 6'b101100); nxt();
        at("jr.D", 3'd1, 6'b000101); chk("jr.pc_src", 8'(pc_src), 8'd2); nxt();
        $display("[TB] jr: 2 cycles");

        op = 6'h3f;
        at("ill.F", 3'd0, 6'b101100); nxt();
        at("ill.D", 3'd1, 6'b000001); chk("ill.D.flag", 8'(illegal), 8'd0); nxt();
        $display("[TB] illegal op 3f: 2 cycles as nop");

        mem_ready = 1'b0;
        at("to.F1", 3'd0, 6'b100000); chk("ill.sticky", 8'(illegal), 8'd1); nxt();
        for (int i = 0; i < 13; i++) begin
            at("to.Fwait", 3'd0, 6'b100000); nxt();
        end
        @(negedge clk);
        chk("to.abort.state", 8'(state), 8'd0);
        chk("to.abort.strobes", 8'(stb & 6'b011111), 8'b000001);
        chk("to.abort.err_pre", 8'(mem_err), 8'd0);
        nxt();
        at("to.after", 3'd0, 6'b100000); chk("to.mem_err", 8'(mem_err), 8'd1); nxt();
        mem_ready = 1'b1;
        at("to.retry", 3'd0, 6'b101100); nxt();
        $display("[TB] fetch timeout after 15 stalled cycles, retried");

        op = 6'h00; funct = 6'h21;
        at("mid.D", 3'd1, 6'b000000); nxt();
        at("mid.E", 3'd2, 6'b000000);
        reset = 1'b1;
        #1;
        chk("mid.rst.state", 8'(state), 8'd0);
        chk("mid.rst.strobes", 8'(stb), 8'd0);
        chk("mid.rst.illegal", 8'(illegal), 8'd0);
        chk("mid.rst.mem_err", 8'(mem_err), 8'd0);
        nxt();
        at("mid.rst.hold", 3'd0, 6'b000000); nxt();
        reset = 1'b0;
        at("mid.F", 3'd0, 6'b101100); nxt();
        $display("[TB] reset mid-instruction abandoned it");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
